// File: rtl/cnn_tile_streamer_if.sv
// Operand/result bus between the tile streamer, the CNN ALU and the byte sink.
// The master side issues ALU beats and drains result bytes.
interface cnn_tile_streamer_if;
  logic        alu_valid;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_b;
  logic        alu_stall;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  modport master (
    output alu_valid, alu_ctrl, alu_b, out_valid, out_byte, out_last,
    input  alu_stall, alu_result, out_ready
  );

  modport slave (
    input  alu_valid, alu_ctrl, alu_b, out_valid, out_byte, out_last,
    output alu_stall, alu_result, out_ready
  );
endinterface

// File: rtl/cnn_tile_streamer.sv
// Feeds the CNN ALU ten preloaded operand words plus one compute beat, then
// streams the captured 32-bit result out MSB-first as four bytes.
module cnn_tile_streamer #(
  parameter int unsigned N_LOAD  = 10,
  parameter logic [2:0]  OP_LOAD = 3'b100,
  parameter logic [2:0]  OP_CONV = 3'b111,
  parameter logic [2:0]  OP_RELU = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [1:0]  op_sel,
  output logic        busy,
  output logic        err,
  output logic        done,
  cnn_tile_streamer_if.master bus
);

  localparam logic [3:0] LAST_IDX = 4'(N_LOAD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  state_t      state;
  logic [31:0] word_buf [N_LOAD];
  logic [3:0]  beat_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] result;
  logic [2:0]  op_latch;
  logic        wr_ok;

  // The buffer only accepts writes while idle so a running tile never sees it change.
  assign wr_ok = wr_en && (state == IDLE) && (wr_addr <= LAST_IDX);

  always_ff @(posedge clk) begin
    if (wr_ok) word_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      err           <= 1'b0;
      done          <= 1'b0;
      bus.alu_valid <= 1'b0;
      bus.alu_ctrl  <= 3'b000;
      bus.alu_b     <= '0;
      bus.out_valid <= 1'b0;
      beat_cnt      <= '0;
      byte_cnt      <= '0;
      result        <= '0;
      op_latch      <= 3'b000;
    end else begin
      err  <= wr_en && ((state != IDLE) || (wr_addr > LAST_IDX));
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_sel[1]) begin
              err <= 1'b1;
            end else begin
              op_latch      <= op_sel[0] ? OP_RELU : OP_CONV;
              beat_cnt      <= '0;
              state         <= LOAD;
              busy          <= 1'b1;
              bus.alu_valid <= 1'b1;
              bus.alu_ctrl  <= OP_LOAD;
              // A same-cycle write to word 0 lands in the first beat.
              bus.alu_b     <= (wr_en && wr_addr == 4'd0) ? wr_data : word_buf[0];
            end
          end
        end
        LOAD: begin
          if (!bus.alu_stall) begin
            if (beat_cnt == LAST_IDX) begin
              state        <= EXEC;
              bus.alu_ctrl <= op_latch;
              bus.alu_b    <= '0;
            end else begin
              beat_cnt  <= beat_cnt + 4'd1;
              bus.alu_b <= word_buf[beat_cnt + 4'd1];
            end
          end
        end
        EXEC: begin
          if (!bus.alu_stall) begin
            result        <= bus.alu_result;
            state         <= DRAIN;
            bus.alu_valid <= 1'b0;
            bus.alu_ctrl  <= 3'b000;
            bus.out_valid <= 1'b1;
            byte_cnt      <= '0;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (byte_cnt == 2'd3) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
              byte_cnt      <= '0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (byte_cnt)
      2'd0:    bus.out_byte = result[31:24];
      2'd1:    bus.out_byte = result[23:16];
      2'd2:    bus.out_byte = result[15:8];
      default: bus.out_byte = result[7:0];
    endcase
    bus.out_last = bus.out_valid && (byte_cnt == 2'd3);
  end

endmodule

// File: doc/cnn_tile_streamer.md
Name: cnn_tile_streamer

Overview:
- Sequencer that feeds the CNN ALU its operand words; it is the writer that drives the ALU's weight/pixel load path.
- Software preloads a 10-entry word buffer. On start, the block issues the 10 load beats (ALUControl 3'b100), then one compute beat (conv 3'b111 or relu 3'b110).
- It captures the 32-bit packed result and drains it as four bytes over a valid/ready stream.
- Sits between the core's datapath mux and the ALU B/ALUControl inputs.

Parameters:
- N_LOAD, 10, number of load beats per tile; buffer depth.
- OP_LOAD, 3'b100, ALU control code for a load beat.
- OP_CONV, 3'b111, ALU control code for convolution.
- OP_RELU, 3'b110, ALU control code for relu.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  buffer write strobe.
- wr_addr  input  4  buffer index, 0..N_LOAD-1.
- wr_data  input  32  buffer word; bits [15:0] carry two 8-bit operands.
- start  input  1  begin tile sequence; single-cycle pulse.
- op_sel  input  2  00 = conv, 01 = relu, 10/11 = illegal.
- busy  output  1  high from accepted start until the last byte is accepted.
- err  output  1  one-cycle pulse on illegal start or illegal write.
- alu_valid  output  1  the alu_b/alu_ctrl beat is live.
- alu_ctrl  output  3  ALUControl driven to the ALU.
- alu_b  output  32  B operand driven to the ALU.
- alu_stall  input  1  core stall; holds the current beat.
- alu_result  input  32  ALU Result.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  downstream accepts a byte.
- out_byte  output  8  result byte.
- out_last  output  1  marks the 4th byte.
- done  output  1  one-cycle pulse when the last byte is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE. busy, err, alu_valid, out_valid, out_last and done all 0. alu_ctrl = 3'b000, alu_b = 0, out_byte = 0, beat counter 0, byte counter 0, result register 0. Buffer contents are not reset.
- Reset asserted mid-operation aborts immediately; the ALU sees alu_valid=0 and alu_ctrl=000 on the same edge.

Buffer:
- In IDLE, wr_en with wr_addr < N_LOAD writes wr_data on the clock edge.
- wr_addr >= N_LOAD: write dropped, err pulses.
- wr_en while busy: write dropped, err pulses. The buffer is never modified mid-tile.

States:
- IDLE:
  - start with op_sel in {00,01}: latch opcode, counter = 0, go to LOAD, busy=1 on the next cycle.
  - start with op_sel in {10,11}: err pulses, stay IDLE.
  - start and wr_en in the same cycle: the write is performed first, and the sequence uses the new word.
- LOAD:
  - Drive alu_valid=1, alu_ctrl=OP_LOAD, alu_b=buf[counter].
  - If alu_stall=0, counter increments at the edge; otherwise the beat is held unchanged.
  - After the beat with counter = N_LOAD-1 completes, go to EXEC.
  - Exactly N_LOAD load beats are issued; an extra load beat (which would clear the ALU registers) must never occur.
- EXEC:
  - Drive alu_valid=1, alu_ctrl = latched opcode, alu_b = 0.
  - On an unstalled edge, register alu_result and go to DRAIN.
  - While stalled, hold and do not capture.
- DRAIN:
  - alu_valid=0, alu_ctrl=000, out_valid=1.
  - out_byte sends result[31:24], [23:16], [15:8], [7:0] in order, advancing on out_valid & out_ready.
  - out_last=1 while the 4th byte is presented.
  - On acceptance of the 4th byte: done pulses, busy=0, return to IDLE.
  - out_ready=0 holds out_byte stable indefinitely.
- start asserted while busy is ignored, with no err.
- Minimum latency with no stalls and out_ready held high: start edge -> 10 LOAD cycles -> 1 EXEC cycle -> 4 DRAIN cycles. done is asserted in the 15th cycle after start is sampled.
- All outputs are registered except out_byte/out_last, which decode from the registered byte counter and result.

Test Plan:
- Write buf[i]=32'h0000_0101*(i+1), start with op_sel=00, alu_result tied to 32'hA1B2C3D4, out_ready=1:
  - alu_b sequence 0x0101..0x0A0A, each beat with ctrl 100.
  - One beat with ctrl 111.
  - Bytes A1, B2, C3, D4, out_last on D4, done in the 15th cycle.
- Same setup with op_sel=01: compute beat uses ctrl 110; exactly 10 load beats, verified by counting ctrl==100 cycles.
- alu_stall high for 3 cycles at load beat 4 and 2 cycles at EXEC:
  - Beat 4 alu_b is held for 4 cycles.
  - alu_result changes to 32'h11223344 during the stall and is 32'h55667788 on the release edge; 0x55 is the first byte out.
- out_ready toggled 1,0,0,1,1,0,1: each byte stays stable while not ready; exactly 4 transfers; done coincides with the 4th.
- start with op_sel=11 -> err pulse, busy stays 0. wr_en with wr_addr=12 in IDLE -> err pulse, buffer unchanged. wr_en during LOAD -> err pulse, alu_b sequence unchanged.
- rst asserted during EXEC: all outputs are zero immediately (async). A following start reruns a full 10-beat sequence with the preserved buffer contents.
